// File: rtl/ctrl_seq_if.sv
// Instruction-memory handshake and datapath control bundle for ctrl_seq.
//   imem_req/imem_addr   : fetch request and address (sequencer -> imem)
//   imem_ack/imem_rdata  : fetch completion and instruction word (imem -> sequencer)
//   ad1/ad2/ad3/we3      : register-file read/write indices and write pulse
//   aluSrc/aluCTR/immOp  : ALU operand select, operation and immediate
//   eq                   : ALU equality flag returned by the datapath
interface ctrl_seq_if #(
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned PC_WIDTH      = 32
);
    logic                     imem_req;
    logic [PC_WIDTH-1:0]      imem_addr;
    logic                     imem_ack;
    logic [31:0]              imem_rdata;
    logic [ADDRESS_WIDTH-1:0] ad1;
    logic [ADDRESS_WIDTH-1:0] ad2;
    logic [ADDRESS_WIDTH-1:0] ad3;
    logic                     we3;
    logic                     aluSrc;
    logic [3:0]               aluCTR;
    logic [DATA_WIDTH-1:0]    immOp;
    logic                     eq;

    modport master (
        output imem_req, imem_addr, ad1, ad2, ad3, we3, aluSrc, aluCTR, immOp,
        input  imem_ack, imem_rdata, eq
    );

    modport slave (
        input  imem_req, imem_addr, ad1, ad2, ad3, we3, aluSrc, aluCTR, immOp,
        output imem_ack, imem_rdata, eq
    );
endinterface

// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer for an RV32I subset (ADDI, ADD, SUB, BNE).
// Fetches over a req/ack handshake, decodes in a single EXEC cycle and
// updates the PC; undecodable words latch 'illegal' and park in HALT.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : ctrl_seq_if master (imem handshake + datapath controls + eq)
//   pc       : current program counter
//   illegal  : sticky flag, set when an undecodable instruction executes
module ctrl_seq #(
    parameter int unsigned         ADDRESS_WIDTH = 5,
    parameter int unsigned         DATA_WIDTH    = 32,
    parameter int unsigned         PC_WIDTH      = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                clk,
    input  logic                rst,
    ctrl_seq_if.master          bus,
    output logic [PC_WIDTH-1:0] pc,
    output logic                illegal
);

    localparam int unsigned ILEN = 32;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ILEN-1:0]     ir;
    logic [PC_WIDTH-1:0] pc_nxt;
    logic                illegal_nxt;

    // Instruction fields
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic       rd_nz;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];
    assign rd_nz  = (rd != 5'd0);

    logic is_addi;
    logic is_add;
    logic is_sub;
    logic is_bne;

    assign is_addi = (opcode == OP_IMM)    && (funct3 == 3'b000);
    assign is_add  = (opcode == OP_REG)    && (funct3 == 3'b000) && (funct7 == 7'b0000000);
    assign is_sub  = (opcode == OP_REG)    && (funct3 == 3'b000) && (funct7 == 7'b0100000);
    assign is_bne  = (opcode == OP_BRANCH) && (funct3 == 3'b001);

    // Sign-extended I-type and B-type immediates
    logic [DATA_WIDTH-1:0] imm_i;
    logic [DATA_WIDTH-1:0] imm_b;

    assign imm_i = {{(DATA_WIDTH-12){ir[31]}}, ir[31:20]};
    assign imm_b = {{(DATA_WIDTH-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

    assign bus.imem_addr = pc;

    // State, PC, instruction register and sticky illegal flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            ir      <= '0;
            illegal <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            illegal <= illegal_nxt;
            if (state == FETCH && bus.imem_ack) begin
                ir <= bus.imem_rdata;
            end
        end
    end

    // Next state, PC update and decoded controls; everything forced idle while rst is high
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        illegal_nxt  = illegal;
        bus.imem_req = 1'b0;
        bus.ad1      = '0;
        bus.ad2      = '0;
        bus.ad3      = '0;
        bus.we3      = 1'b0;
        bus.aluSrc   = 1'b0;
        bus.aluCTR   = ALU_ADD;
        bus.immOp    = '0;

        if (!rst) begin
            unique case (state)
                FETCH: begin
                    bus.imem_req = 1'b1;
                    if (bus.imem_ack) begin
                        state_nxt = EXEC;
                    end
                end
                EXEC: begin
                    bus.ad1   = ADDRESS_WIDTH'(ir[19:15]);
                    bus.ad2   = ADDRESS_WIDTH'(ir[24:20]);
                    bus.ad3   = ADDRESS_WIDTH'(rd);
                    state_nxt = FETCH;
                    pc_nxt    = pc + PC_WIDTH'(4);
                    if (is_addi) begin
                        bus.aluSrc = 1'b1;
                        bus.aluCTR = ALU_ADD;
                        bus.immOp  = imm_i;
                        bus.we3    = rd_nz;
                    end else if (is_add || is_sub) begin
                        bus.aluCTR = is_sub ? ALU_SUB : ALU_ADD;
                        bus.we3    = rd_nz;
                    end else if (is_bne) begin
                        bus.aluCTR = ALU_SUB;
                        bus.immOp  = imm_b;
                        if (!bus.eq) begin
                            pc_nxt = pc + PC_WIDTH'(imm_b);
                        end
                    end else begin
                        state_nxt   = HALT;
                        pc_nxt      = pc;
                        illegal_nxt = 1'b1;
                    end
                end
                HALT: begin
                    state_nxt = HALT;
                end
                default: begin
                    state_nxt = FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_seq.sv
// Randomized self-checking bench for ctrl_seq against an instruction-level reference model.
module tb_ctrl_seq;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned PW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] pc;
    logic          illegal;

    always #5 clk = ~clk;

    ctrl_seq_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .PC_WIDTH(PW)) bus ();

    ctrl_seq #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .PC_WIDTH     (PW),
        .RESET_PC     ('0)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .pc     (pc),
        .illegal(illegal)
    );

    typedef struct packed {
        logic        legal;
        logic        bne;
        logic        we3;
        logic        alusrc;
        logic [3:0]  aluctr;
        logic        chk_imm;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } exp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_pc;
    logic        m_illegal;

    // Architectural meaning of one instruction word
    function automatic exp_t decode_ref(input logic [31:0] w);
        exp_t        e;
        logic [31:0] op;
        logic [31:0] f3;
        logic [31:0] f7;
        e   = '0;
        op  = w & 32'h7f;
        f3  = (w >> 12) & 32'h7;
        f7  = w >> 25;
        e.rd  = w[11:7];
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        if (op == 32'd19 && f3 == 32'd0) begin
            e.legal = 1'b1; e.we3 = (e.rd != 5'd0); e.alusrc = 1'b1; e.aluctr = 4'd0;
            e.chk_imm = 1'b1; e.imm = $signed(w) >>> 20;
        end else if (op == 32'd51 && f3 == 32'd0 && (f7 == 32'd0 || f7 == 32'd32)) begin
            e.legal = 1'b1; e.we3 = (e.rd != 5'd0); e.alusrc = 1'b0;
            e.aluctr = (f7 == 32'd32) ? 4'd1 : 4'd0;
        end else if (op == 32'd99 && f3 == 32'd1) begin
            e.legal = 1'b1; e.bne = 1'b1; e.we3 = 1'b0; e.alusrc = 1'b0; e.aluctr = 4'd1;
            e.chk_imm = 1'b1;
            e.imm = ((w >> 8) & 32'd15) * 32'd2 + ((w >> 25) & 32'd63) * 32'd32
                  + ((w >> 7) & 32'd1) * 32'd2048 - ((w >> 31) & 32'd1) * 32'd4096;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
        logic [31:0] w;
        rd  = 5'($urandom_range(0, 31));
        rs1 = 5'($urandom_range(0, 31));
        rs2 = 5'($urandom_range(0, 31));
        imm = 12'($urandom);
        case ($urandom_range(0, 3))
            0:       w = {imm, rs1, 3'b000, rd, 7'b0010011};
            1:       w = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            2:       w = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
            default: w = {imm[11:5], rs2, rs1, 3'b001, imm[4:0], 7'b1100011};
        endcase
        return w;
    endfunction

    // Fetch (with 'delay' wait cycles) and execute one instruction, checking every cycle
    task automatic do_instr(input logic [31:0] w, input logic eqv, input int delay);
        exp_t e;
        e = decode_ref(w);
        for (int i = 0; i <= delay; i++) begin
            n_tests++;
            if ({bus.imem_req, bus.imem_addr, bus.we3, bus.aluSrc, bus.aluCTR, bus.immOp,
                 bus.ad1, bus.ad2, bus.ad3} !== {1'b1, m_pc, 1'b0, 1'b0, 4'd0, 32'd0, 15'd0}) begin
                n_fail++;
                $display("FAIL fetch: req=%b addr=%h we3=%b aluSrc=%b aluCTR=%h immOp=%h ad=%h/%h/%h, expected req=1 addr=%h controls 0",
                         bus.imem_req, bus.imem_addr, bus.we3, bus.aluSrc, bus.aluCTR, bus.immOp,
                         bus.ad1, bus.ad2, bus.ad3, m_pc);
            end
            bus.imem_ack   = (i == delay);
            bus.imem_rdata = (i == delay) ? w : $urandom;
            @(negedge clk);
        end
        n_tests++;
        if ({bus.imem_req, bus.we3, bus.ad1, bus.ad2, bus.ad3} !== {1'b0, e.we3, e.rs1, e.rs2, e.rd}) begin
            n_fail++;
            $display("FAIL exec_ctrl (instr %h): req=%b we3=%b ad1=%0d ad2=%0d ad3=%0d, expected req=0 we3=%b ad1=%0d ad2=%0d ad3=%0d",
                     w, bus.imem_req, bus.we3, bus.ad1, bus.ad2, bus.ad3, e.we3, e.rs1, e.rs2, e.rd);
        end
        if (e.legal) begin
            n_tests++;
            if ({bus.aluSrc, bus.aluCTR} !== {e.alusrc, e.aluctr}) begin
                n_fail++;
                $display("FAIL exec_alu (instr %h): aluSrc=%b aluCTR=%h, expected aluSrc=%b aluCTR=%h",
                         w, bus.aluSrc, bus.aluCTR, e.alusrc, e.aluctr);
            end
        end
        if (e.chk_imm) begin
            n_tests++;
            if (bus.immOp !== e.imm) begin
                n_fail++;
                $display("FAIL exec_imm (instr %h): immOp=%h, expected %h", w, bus.immOp, e.imm);
            end
        end
        bus.eq         = eqv;
        bus.imem_ack   = 1'($urandom_range(0, 1));
        bus.imem_rdata = $urandom;
        @(negedge clk);
        if (!e.legal)             m_illegal = 1'b1;
        else if (e.bne && !eqv)   m_pc = m_pc + e.imm;
        else                      m_pc = m_pc + 32'd4;
        n_tests++;
        if ({pc, illegal} !== {m_pc, m_illegal}) begin
            n_fail++;
            $display("FAIL pc_update (instr %h eq=%b): pc=%h illegal=%b, expected pc=%h illegal=%b",
                     w, eqv, pc, illegal, m_pc, m_illegal);
        end
        bus.imem_ack = 1'b0;
        bus.eq       = 1'($urandom_range(0, 1));
    endtask

    // Apply reset for two edges and check idle-then-fetch behaviour
    task automatic do_reset();
        rst          = 1'b1;
        bus.imem_ack = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({bus.imem_req, bus.we3} !== 2'b00) begin
            n_fail++;
            $display("FAIL in_reset: req=%b we3=%b, expected 0 0", bus.imem_req, bus.we3);
        end
        @(negedge clk);
        rst       = 1'b0;
        m_pc      = '0;
        m_illegal = 1'b0;
        #1;
        n_tests++;
        if ({bus.imem_req, bus.imem_addr, pc, bus.we3, illegal} !== {1'b1, 32'd0, 32'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL after_reset: req=%b addr=%h pc=%h we3=%b illegal=%b, expected 1 0 0 0 0",
                     bus.imem_req, bus.imem_addr, pc, bus.we3, illegal);
        end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_addi();
        do_instr(32'h00500093, 1'b0, 2);
    endtask

    task automatic test_bne();
        do_instr(32'h00000013, 1'b0, 0);
        do_instr(32'hFE209EE3, 1'b0, 1);
        do_instr(32'h00000013, 1'b1, 0);
        do_instr(32'hFE209EE3, 1'b1, 0);
    endtask

    task automatic test_sub();
        do_instr(32'h40208033, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 60; n++) begin
            do_instr(rand_instr(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_illegal();
        do_instr(32'h00000000, 1'b0, 1);
        for (int i = 0; i < 12; i++) begin
            bus.imem_ack   = 1'($urandom_range(0, 1));
            bus.imem_rdata = 32'h00500093;
            @(negedge clk);
            n_tests++;
            if ({bus.imem_req, bus.we3, pc, illegal} !== {1'b0, 1'b0, m_pc, 1'b1}) begin
                n_fail++;
                $display("FAIL halt_hold: req=%b we3=%b pc=%h illegal=%b, expected req=0 we3=0 pc=%h illegal=1",
                         bus.imem_req, bus.we3, pc, illegal, m_pc);
            end
        end
        do_reset();
        do_instr(32'h00700113, 1'b0, 0);
    endtask

    task automatic test_rst_priority();
        // reset colliding with an ack: no load, no execute
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h00500093;
        rst            = 1'b1;
        #1;
        n_tests++;
        if ({bus.imem_req, bus.we3} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_ack_gate: req=%b we3=%b, expected 0 0", bus.imem_req, bus.we3);
        end
        @(negedge clk);
        rst          = 1'b0;
        bus.imem_ack = 1'b0;
        m_pc         = '0;
        m_illegal    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if ({bus.imem_req, bus.imem_addr, bus.we3, pc} !== {1'b1, 32'd0, 1'b0, 32'd0}) begin
                n_fail++;
                $display("FAIL rst_ack_refetch: req=%b addr=%h we3=%b pc=%h, expected req=1 addr=0 we3=0 pc=0",
                         bus.imem_req, bus.imem_addr, bus.we3, pc);
            end
            @(negedge clk);
        end
        // reset during an EXEC of a register-writing instruction
        do_instr(32'h00000013, 1'b0, 0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h00700193;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        rst          = 1'b1;
        #1;
        n_tests++;
        if (bus.we3 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_exec_we3: we3=%b, expected 0", bus.we3);
        end
        @(negedge clk);
        rst       = 1'b0;
        m_pc      = '0;
        m_illegal = 1'b0;
        #1;
        n_tests++;
        if ({pc, illegal, bus.imem_req, bus.imem_addr} !== {32'd0, 1'b0, 1'b1, 32'd0}) begin
            n_fail++;
            $display("FAIL rst_exec_pc: pc=%h illegal=%b req=%b addr=%h, expected pc=0 illegal=0 req=1 addr=0",
                     pc, illegal, bus.imem_req, bus.imem_addr);
        end
        do_instr(32'h00500093, 1'b0, 0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        bus.eq         = 1'b0;
        m_pc           = '0;
        m_illegal      = 1'b0;
        @(negedge clk);
        test_reset();
        test_addi();
        test_bne();
        test_sub();
        test_back_to_back();
        test_rst_priority();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
